// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   DW, AW    : data and register-address widths of the register file
//   wb_req_t  : one register-file write request (destination + data)
//   REG_ZERO  : address of the hard-wired zero register, never written
package wb_pkg;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic [AW-1:0] wr;
    logic [DW-1:0] wd;
  } wb_req_t;

  localparam logic [AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of write requests for the multi-cycle producer.
//   clk, rst    : clock, synchronous active-high reset (empties the FIFO)
//   push, data  : enqueue data at posedge (ignored when full)
//   pop         : dequeue head at posedge (ignored when empty)
//   full, empty : status from the registered count
//   count       : number of valid entries
//   head        : oldest entry
//   entries     : raw storage, with entry_valid marking occupied slots
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  wb_req_t                     data,
  input  logic                        pop,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count,
  output wb_req_t                     head,
  output wb_req_t [DEPTH-1:0]         entries,
  output logic [DEPTH-1:0]            entry_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req_t [DEPTH-1:0] mem;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic                push_ok;
  logic                pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign entries = mem;

  // A slot is occupied when its distance from the read pointer (mod DEPTH)
  // is below the count; DEPTH is a power of two so the subtraction wraps.
  always_comb begin
    logic [PW-1:0] off;
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off            = PW'(i) - rd_ptr;
      entry_valid[i] = ({1'b0, off} < count);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the pipeline writeback (A,
// highest priority, no handshake) and a multi-cycle unit (B, valid/ready,
// buffered in wb_fifo). Requests a pipeline stall when the B head starves and
// exports a mask of registers with queued B writes for the hazard unit.
//   clk, rst                : clock, synchronous active-high reset
//   a_valid, a_wr, a_wd     : pipeline writeback request
//   b_valid, b_ready        : B handshake; a transfer happens when both are
//                             high at posedge. b_ready depends only on the
//                             registered FIFO count, never on b_valid or on a
//                             same-cycle pop.
//   b_wr, b_wd              : B request payload
//   stall_req               : hold pipeline writeback (a_valid must stay 0)
//   pend_mask               : bit r set iff a queued B entry targets r
//   rf_regwrite, rf_wr, rf_wd : register-file write port
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DW           = wb_pkg::DW,
  parameter int AW           = wb_pkg::AW,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [AW-1:0]     a_wr,
  input  logic [DW-1:0]     a_wd,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [AW-1:0]     b_wr,
  input  logic [DW-1:0]     b_wd,
  output logic              stall_req,
  output logic [2**AW-1:0]  pend_mask,
  output logic              rf_regwrite,
  output logic [AW-1:0]     rf_wr,
  output logic [DW-1:0]     rf_wd
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic                     fifo_full;
  logic                     fifo_empty;
  logic [CW-1:0]            fifo_count;
  wb_req_t                  fifo_head;
  wb_req_t [FIFO_DEPTH-1:0] fifo_entries;
  logic [FIFO_DEPTH-1:0]    fifo_entry_valid;
  logic                     fifo_push;
  logic                     fifo_pop;
  wb_req_t                  b_req;
  logic                     a_eff;
  logic [SW-1:0]            starve_cnt;

  assign a_eff     = a_valid && (a_wr != REG_ZERO);
  assign b_ready   = !rst && (fifo_count < CW'(FIFO_DEPTH));
  assign b_req     = '{wr: b_wr, wd: b_wd};
  // Writes to r0 complete the handshake but never occupy a slot.
  assign fifo_push = b_valid && !fifo_full && (b_wr != REG_ZERO);
  // Head leaves when it is granted, or when A overwrites the same register
  // this cycle (A's value is newer, so the queued one is stale).
  assign fifo_pop  = !rst && !fifo_empty && (!a_eff || (fifo_head.wr == a_wr));
  assign stall_req = !rst && (starve_cnt == SW'(STARVE_LIMIT));

  wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (fifo_push),
    .data        (b_req),
    .pop         (fifo_pop),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count       (fifo_count),
    .head        (fifo_head),
    .entries     (fifo_entries),
    .entry_valid (fifo_entry_valid)
  );

  always_comb begin
    rf_regwrite = 1'b0;
    rf_wr       = '0;
    rf_wd       = '0;
    if (!rst) begin
      if (a_eff) begin
        rf_regwrite = 1'b1;
        rf_wr       = a_wr;
        rf_wd       = a_wd;
      end else if (!fifo_empty) begin
        rf_regwrite = 1'b1;
        rf_wr       = fifo_head.wr;
        rf_wd       = fifo_head.wd;
      end
    end
  end

  always_comb begin
    pend_mask = '0;
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (fifo_entry_valid[i]) pend_mask[fifo_entries[i].wr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (fifo_empty || fifo_pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  import wb_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_valid;
  logic [4:0]  a_wr;
  logic [31:0] a_wd;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_wr;
  logic [31:0] b_wd;
  logic        stall_req;
  logic [31:0] pend_mask;
  logic        rf_regwrite;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wd;

  wb_port_arbiter #(
    .DW(32), .AW(5), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_wr(a_wr), .a_wd(a_wd),
    .b_valid(b_valid), .b_ready(b_ready), .b_wr(b_wr), .b_wd(b_wd),
    .stall_req(stall_req), .pend_mask(pend_mask),
    .rf_regwrite(rf_regwrite), .rf_wr(rf_wr), .rf_wd(rf_wd)
  );

  // ---------------- reference model ----------------
  // Pending B writes as a plain queue in arrival order, plus the number of
  // cycles the oldest one has been waiting.
  typedef struct {
    logic [4:0]  wr;
    logic [31:0] wd;
  } ent_t;

  ent_t        mq[$];
  int          mwait;
  logic [36:0] exp_q[$];

  int checks   = 0;
  int failures = 0;

  logic        obs_we, obs_ready, obs_stall;
  logic [4:0]  obs_wr;
  logic [31:0] obs_wd, obs_mask;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic drive(input logic r, input logic av, input logic [4:0] aw,
                       input logic [31:0] ad, input logic bv,
                       input logic [4:0] bw, input logic [31:0] bd);
    logic        aeff, e_we, e_ready, e_stall, pops;
    logic [4:0]  e_wr;
    logic [31:0] e_wd, e_mask;
    // The pipeline honours a stall request that is already visible.
    if (!r && mwait == LIMIT) av = 1'b0;
    rst = r; a_valid = av; a_wr = aw; a_wd = ad;
    b_valid = bv; b_wr = bw; b_wd = bd;
    #1;
    obs_we = rf_regwrite; obs_wr = rf_wr; obs_wd = rf_wd;
    obs_ready = b_ready; obs_stall = stall_req; obs_mask = pend_mask;

    aeff = av && (aw != 5'd0);
    e_we = 1'b0; e_wr = '0; e_wd = '0; pops = 1'b0;
    if (!r) begin
      if (aeff) begin
        e_we = 1'b1; e_wr = aw; e_wd = ad;
        pops = (mq.size() > 0) && (mq[0].wr == aw);
      end else if (mq.size() > 0) begin
        e_we = 1'b1; e_wr = mq[0].wr; e_wd = mq[0].wd;
        pops = 1'b1;
      end
    end
    e_ready = !r && (mq.size() < DEPTH);
    e_stall = !r && (mwait == LIMIT);
    e_mask  = '0;
    if (!r) foreach (mq[i]) e_mask[mq[i].wr] = 1'b1;
    if (e_we) exp_q.push_back({e_wr, e_wd});

    check("regwrite", obs_we, e_we);
    check("b_ready", obs_ready, e_ready);
    check("stall_req", obs_stall, e_stall);
    check("pend_mask", obs_mask, e_mask);
    if (obs_we) begin
      if (exp_q.size() == 0) check("spurious_write", 1, 0);
      else check("write", {obs_wr, obs_wd}, exp_q.pop_front());
    end else begin
      check("rf_idle", {obs_wr, obs_wd}, 0);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    check("a_hold", av && obs_stall, 0);

    if (r) begin
      mq.delete();
      mwait = 0;
    end else begin
      if (mq.size() == 0 || pops) mwait = 0;
      else if (mwait < LIMIT) mwait++;
      if (pops) void'(mq.pop_front());
      if (bv && e_ready && bw != 5'd0) mq.push_back('{bw, bd});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1; a_valid = 0; a_wr = 0; a_wd = 0; b_valid = 0; b_wr = 0; b_wd = 0;
    mwait = 0;

    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    check("rst_ready", obs_ready, 0);

    // Reset then idle
    idle();
    check("idle_ready", obs_ready, 1);
    check("idle_we", obs_we, 0);
    check("idle_mask", obs_mask, 0);
    check("idle_stall", obs_stall, 0);

    // B only
    drive(0, 0, 0, 0, 1, 5, 32'hDEAD_BEEF);
    idle();
    check("bonly_mask5", obs_mask[5], 1);
    check("bonly_we", obs_we, 1);
    check("bonly_wr", obs_wr, 5);
    check("bonly_wd", obs_wd, 32'hDEAD_BEEF);
    idle();
    check("bonly_mask_clr", obs_mask, 0);

    // Back-pressure
    drive(0, 1, 3, 32'h33, 1, 7, 32'h77);
    drive(0, 1, 3, 32'h34, 1, 8, 32'h88);
    drive(0, 1, 3, 32'h35, 1, 9, 32'h99);
    check("bp_ready", obs_ready, 0);
    check("bp_a_wr", obs_wr, 3);
    idle();
    check("bp_r7", {obs_wr, obs_wd}, {5'd7, 32'h77});
    idle();
    check("bp_r8", {obs_wr, obs_wd}, {5'd8, 32'h88});
    idle();
    check("bp_drained", obs_we, 0);

    // Starvation
    drive(0, 1, 9, 32'h90, 1, 10, 32'hA0);
    for (int i = 0; i < 4; i++) drive(0, 1, 9, 32'h91 + i, 0, 0, 0);
    check("starve_pre", obs_stall, 0);
    drive(0, 1, 9, 32'h99, 0, 0, 0);
    check("starve_stall", obs_stall, 1);
    check("starve_headwr", {obs_wr, obs_wd}, {5'd10, 32'hA0});
    idle();
    check("starve_drop", obs_stall, 0);

    // Conflict
    drive(0, 1, 3, 32'h30, 1, 4, 32'h44);
    drive(0, 1, 4, 32'h11, 0, 0, 0);
    check("conf_mask_set", obs_mask[4], 1);
    check("conf_write", {obs_wr, obs_wd}, {5'd4, 32'h11});
    idle();
    check("conf_mask_clr", obs_mask, 0);
    check("conf_no_write", obs_we, 0);

    // Zero register and reset
    drive(0, 1, 0, 32'h55, 1, 0, 32'h66);
    check("r0_a_we", obs_we, 0);
    check("r0_b_ready", obs_ready, 1);
    idle();
    check("r0_b_mask", obs_mask, 0);
    check("r0_b_we", obs_we, 0);
    drive(0, 1, 3, 32'h1, 1, 7, 32'h2);
    drive(0, 1, 3, 32'h1, 1, 8, 32'h3);
    drive(1, 0, 0, 0, 0, 0, 0);
    check("rst_mid_we", obs_we, 0);
    idle();
    check("rst_mid_mask", obs_mask, 0);
    check("rst_mid_we2", obs_we, 0);
    check("rst_mid_ready", obs_ready, 1);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
